// File: rtl/tbird_pkg.sv
// rtl/tbird_pkg.sv - shared lamp codes, scheduler/command enums and helpers
package tbird_pkg;

  localparam logic [2:0] LAMP_IDLE = 3'b000;
  localparam logic [2:0] LAMP_LR3  = 3'b001;
  localparam logic [2:0] LAMP_R1   = 3'b010;
  localparam logic [2:0] LAMP_R2   = 3'b011;
  localparam logic [2:0] LAMP_R3   = 3'b100;
  localparam logic [2:0] LAMP_L1   = 3'b101;
  localparam logic [2:0] LAMP_L2   = 3'b110;
  localparam logic [2:0] LAMP_L3   = 3'b111;

  typedef enum logic [1:0] {
    SCHED_OFF,
    SCHED_RUN,
    SCHED_DRAIN
  } sched_state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_LEFT,
    CMD_RIGHT,
    CMD_HAZ
  } cmd_t;

  // Hazard wins, and both levers together also mean hazard
  function automatic cmd_t arbitrate(input logic l, input logic r, input logic h);
    cmd_t c;
    if (h || (l && r)) c = CMD_HAZ;
    else if (l)        c = CMD_LEFT;
    else if (r)        c = CMD_RIGHT;
    else               c = CMD_NONE;
    return c;
  endfunction

  // Last lit state of a sweep; leaving it completes one sequence
  function automatic logic is_seq_end(input logic [2:0] s);
    return (s == LAMP_R3) || (s == LAMP_L3) || (s == LAMP_LR3);
  endfunction

endpackage

// File: rtl/lever_debounce.sv
// rtl/lever_debounce.sv - per-lever debounce on consecutive differing samples
module lever_debounce
#(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw,
  output logic level
);

  logic [3:0] cnt;

  // count differing samples; any agreeing sample restarts the count
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      level <= 1'b0;
      cnt   <= 4'd0;
    end else if (raw != level) begin
      if (cnt == 4'(DEB_CYCLES - 1)) begin
        level <= raw;
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end else begin
      cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/tbird_step_scheduler.sv
// rtl/tbird_step_scheduler.sv - debounce, arbitration and step pacing for the tail-light FSM
module tbird_step_scheduler
  import tbird_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int DEB_CYCLES = 3
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       haz_in,
  input  logic [2:0] ctl_state,
  output logic       step,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic       cmd_haz,
  output logic       busy,
  output logic [7:0] seq_count
);

  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);
  // command loads on the edge that enters the step cycle so the lamp samples it with the step
  localparam logic [7:0] DIV_LOAD = 8'(TICK_DIV - 2);

  logic         left_db, right_db, haz_db;
  cmd_t         req, cmd_q;
  sched_state_t state_q, state_d;
  logic [7:0]   div_q, div_d;
  logic         wrap, load_edge, hold_idle;

  lever_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left  (.clk(clk), .clr_n(clr_n), .raw(left_in),  .level(left_db));
  lever_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (.clk(clk), .clr_n(clr_n), .raw(right_in), .level(right_db));
  lever_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_haz   (.clk(clk), .clr_n(clr_n), .raw(haz_in),   .level(haz_db));

  assign req       = arbitrate(left_db, right_db, haz_db);
  assign wrap      = (div_q == DIV_LAST);
  assign load_edge = (state_q != SCHED_OFF) && (div_q == DIV_LOAD);
  // a step at IDLE with nothing commanded would start a spurious sweep
  assign hold_idle = (ctl_state == LAMP_IDLE) && ((state_q == SCHED_DRAIN) || (cmd_q == CMD_NONE));

  // next state, divider advance and step decode
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    step    = 1'b0;
    case (state_q)
      SCHED_OFF: begin
        div_d = 8'd0;
        if (req != CMD_NONE) state_d = SCHED_RUN;
      end
      SCHED_RUN: begin
        div_d = wrap ? 8'd0 : div_q + 8'd1;
        step  = wrap && !hold_idle;
        if (req == CMD_NONE) state_d = SCHED_DRAIN;
      end
      SCHED_DRAIN: begin
        div_d = wrap ? 8'd0 : div_q + 8'd1;
        step  = wrap && !hold_idle;
        if (req != CMD_NONE)                          state_d = SCHED_RUN;
        else if (wrap && (ctl_state == LAMP_IDLE))    state_d = SCHED_OFF;
      end
      default: begin
        state_d = SCHED_OFF;
        div_d   = 8'd0;
      end
    endcase
  end

  // state, divider and busy registers
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= SCHED_OFF;
      div_q   <= 8'd0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      busy    <= (state_d != SCHED_OFF);
    end
  end

  // command register: hazard preempts, left/right only swap between sweeps
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cmd_q <= CMD_NONE;
    end else if ((state_q == SCHED_DRAIN) && (load_edge || (state_d == SCHED_OFF))) begin
      cmd_q <= CMD_NONE;
    end else if ((state_q == SCHED_RUN) && load_edge &&
                 ((req == CMD_HAZ) || (ctl_state == LAMP_IDLE))) begin
      cmd_q <= req;
    end
  end

  // completed-sequence counter, bumped when a step leaves a final lamp state
  always_ff @(posedge clk) begin
    if (!clr_n)                               seq_count <= 8'd0;
    else if (step && is_seq_end(ctl_state))   seq_count <= seq_count + 8'd1;
  end

  assign cmd_left  = (cmd_q == CMD_LEFT);
  assign cmd_right = (cmd_q == CMD_RIGHT);
  assign cmd_haz   = (cmd_q == CMD_HAZ);

endmodule

// File: tb/tb_tbird_step_scheduler.sv
// tb/tb_tbird_step_scheduler.sv - closed-loop scoreboard bench for tbird_step_scheduler
module tb_tbird_step_scheduler;
  import tbird_pkg::*;

  localparam logic [2:0] CN = 3'b000;
  localparam logic [2:0] CL = 3'b100;
  localparam logic [2:0] CR = 3'b010;
  localparam logic [2:0] CH = 3'b001;

  logic       clk = 1'b0;
  logic       clr_n, left_in, right_in, haz_in;
  logic [2:0] ctl_state;
  logic       step, cmd_left, cmd_right, cmd_haz, busy;
  logic [7:0] seq_count;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_exp;
  logic       seen;

  always #5 clk = ~clk;

  tbird_step_scheduler #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .clk(clk), .clr_n(clr_n), .left_in(left_in), .right_in(right_in), .haz_in(haz_in),
    .ctl_state(ctl_state), .step(step), .cmd_left(cmd_left), .cmd_right(cmd_right),
    .cmd_haz(cmd_haz), .busy(busy), .seq_count(seq_count)
  );

  function automatic logic [2:0] lamp_next(input logic [2:0] s, input logic l, input logic r, input logic h);
    if (s == LAMP_IDLE) begin
      if (h || (l && r)) return LAMP_LR3;
      if (l) return LAMP_L1;
      if (r) return LAMP_R1;
      return LAMP_LR3;
    end
    if (s == LAMP_LR3) return LAMP_IDLE;
    if (h) return LAMP_LR3;
    case (s)
      LAMP_L1: return LAMP_L2;
      LAMP_L2: return LAMP_L3;
      LAMP_R1: return LAMP_R2;
      LAMP_R2: return LAMP_R3;
      default: return LAMP_IDLE;
    endcase
  endfunction

  // lamp controller model, clock-enabled by step
  always_ff @(posedge clk) begin
    if (!clr_n)    ctl_state <= LAMP_IDLE;
    else if (step) ctl_state <= lamp_next(ctl_state, cmd_left, cmd_right, cmd_haz);
  end

  // monitor: every step pulse pops one expected {cmd, lamp state}
  always @(negedge clk) begin
    if (step === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL step_unexpected: got step with cmd(lrh)=%b state=%b, required no step",
                 {cmd_left, cmd_right, cmd_haz}, ctl_state);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({cmd_left, cmd_right, cmd_haz, ctl_state} !== mon_exp) begin
          errors++;
          $display("FAIL step_content: got cmd(lrh)=%b state=%b, required cmd=%b state=%b",
                   {cmd_left, cmd_right, cmd_haz}, ctl_state, mon_exp[5:3], mon_exp[2:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [2:0] s);
    exp_q.push_back({c, s});
  endtask

  task automatic wait_lamp(input logic [2:0] s, input int limit);
    int n = 0;
    while (ctl_state !== s && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (ctl_state !== s) begin
      checks++;
      errors++;
      $display("FAIL wait_lamp: got state %b after %0d cycles, required %b", ctl_state, n, s);
    end
  endtask

  task automatic wait_seq(input logic [7:0] v, input int limit);
    int n = 0;
    while (seq_count !== v && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (seq_count !== v) begin
      checks++;
      errors++;
      $display("FAIL wait_seq: got %0d required %0d", seq_count, v);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask

  initial begin
    clr_n = 1'b0; left_in = 1'b0; right_in = 1'b0; haz_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_step", step, 0);
    check("rst_cmd", {cmd_left, cmd_right, cmd_haz}, 0);
    check("rst_busy", busy, 0);
    check("rst_seq", seq_count, 0);
    clr_n = 1'b1;

    // two-cycle glitch never gets through the debouncer
    @(negedge clk);
    left_in = 1'b1;
    repeat (2) @(negedge clk);
    left_in = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | step | busy;
    end
    check("glitch_quiet", seen, 0);

    // left held: timing of busy and first step, then release during second L2
    push(CL, LAMP_IDLE); push(CL, LAMP_L1); push(CL, LAMP_L2); push(CL, LAMP_L3);
    push(CL, LAMP_IDLE); push(CL, LAMP_L1); push(CL, LAMP_L2); push(CN, LAMP_L3);
    left_in = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_before_entry", busy, 0);
    @(negedge clk);
    check("busy_rise", busy, 1);
    check("no_step_at_entry", step, 0);
    repeat (3) @(negedge clk);
    check("first_step", step, 1);
    check("first_cmd_left", cmd_left, 1);
    wait_seq(8'd1, 40);
    wait_lamp(LAMP_L2, 40);
    left_in = 1'b0;
    wait_idle(40);
    check("drain_seq", seq_count, 2);
    check("drain_cmd", {cmd_left, cmd_right, cmd_haz}, 0);
    check("drain_lamp", ctl_state, LAMP_IDLE);
    repeat (8) @(negedge clk);

    // right joins left in L1 (hazard), left drops, then hazard lever in R2
    push(CL, LAMP_IDLE); push(CL, LAMP_L1); push(CH, LAMP_L2); push(CH, LAMP_LR3);
    push(CR, LAMP_IDLE); push(CR, LAMP_R1); push(CR, LAMP_R2); push(CH, LAMP_R3);
    push(CH, LAMP_LR3);
    left_in = 1'b1;
    wait_lamp(LAMP_L1, 40);
    right_in = 1'b1;
    wait_lamp(LAMP_L2, 20);
    check("right_held_off", cmd_right, 0);
    check("left_kept", cmd_left, 1);
    wait_lamp(LAMP_LR3, 20);
    left_in = 1'b0;
    wait_lamp(LAMP_R2, 40);
    haz_in = 1'b1;
    wait_lamp(LAMP_LR3, 20);
    haz_in = 1'b0;
    right_in = 1'b0;
    wait_idle(40);
    check("mix_seq", seq_count, 5);
    check("mix_cmd", {cmd_left, cmd_right, cmd_haz}, 0);
    repeat (8) @(negedge clk);

    // reset mid-L3, then a fresh debounce before restart
    push(CL, LAMP_IDLE); push(CL, LAMP_L1); push(CL, LAMP_L2);
    left_in = 1'b1;
    wait_lamp(LAMP_L3, 60);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    check("clr_step", step, 0);
    check("clr_cmd", {cmd_left, cmd_right, cmd_haz}, 0);
    check("clr_busy", busy, 0);
    check("clr_seq", seq_count, 0);
    repeat (3) @(negedge clk);
    check("restart_debounce", busy, 0);
    @(negedge clk);
    check("restart_busy", busy, 1);
    push(CL, LAMP_IDLE); push(CL, LAMP_L1); push(CN, LAMP_L2); push(CN, LAMP_L3);
    wait_lamp(LAMP_L1, 40);
    left_in = 1'b0;
    wait_idle(60);
    check("restart_seq", seq_count, 1);
    repeat (8) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
